// File: rtl/charbuf_pkg.sv
// Shared constants, command codes and FSM states
// for the character-buffer scroll/clear engine.
package charbuf_pkg;

  localparam int COLS        = 80;
  localparam int ROWS        = 30;
  localparam int ADDR_W      = 12;
  localparam int DATA_W      = 8;
  localparam int SCREEN_SIZE = COLS * ROWS;
  localparam int SCROLL_LAST = COLS * (ROWS - 1) - 1;

  typedef enum logic [1:0] {
    CMD_NOP       = 2'b00,
    CMD_SCROLL    = 2'b01,
    CMD_CLEAR     = 2'b10,
    CMD_FILL_LINE = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    IDLE,
    SCR_RD,
    SCR_CAP,
    SCR_WR,
    FILL,
    DONE
  } state_e;

  // line * 80 as 16*l + 64*l, no multiplier
  function automatic logic [ADDR_W-1:0] line_base(
    input logic [4:0] l
  );
    logic [ADDR_W-1:0] w;
    w = ADDR_W'(l);
    return (w << 4) + (w << 6);
  endfunction

endpackage

// File: rtl/charbuf_scroll_ctrl.sv
// Charbuf port-A owner: CPU accesses win the port,
// the scroll/clear/fill engine stalls behind them.
module charbuf_scroll_ctrl
  import charbuf_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  input  logic [1:0]        cmd_i,
  input  logic [DATA_W-1:0] fill_char_i,
  input  logic [4:0]        line_i,
  input  logic              abort_i,
  output logic              cmd_ready_o,
  output logic              busy_o,
  output logic              done_o,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] fchar_q, fchar_d;

  logic [ADDR_W-1:0] eng_addr;
  logic              eng_we;
  logic [DATA_W-1:0] eng_wdata;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      end_q   <= '0;
      hold_q  <= '0;
      fchar_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      end_q   <= end_d;
      hold_q  <= hold_d;
      fchar_q <= fchar_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    end_d     = end_q;
    hold_d    = hold_q;
    fchar_d   = fchar_q;
    eng_addr  = '0;
    eng_we    = 1'b0;
    eng_wdata = '0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          fchar_d = fill_char_i;
          unique case (1'b1)
            (cmd_i == CMD_SCROLL): begin
              idx_d   = '0;
              state_d = SCR_RD;
            end
            (cmd_i == CMD_CLEAR): begin
              idx_d   = '0;
              end_d   = ADDR_W'(SCREEN_SIZE - 1);
              state_d = FILL;
            end
            (cmd_i == CMD_FILL_LINE): begin
              if (line_i >= 5'(ROWS)) begin
                state_d = DONE;
              end else begin
                idx_d   = line_base(line_i);
                end_d   = line_base(line_i)
                        + ADDR_W'(COLS - 1);
                state_d = FILL;
              end
            end
            default: ;
          endcase
        end
      end
      SCR_RD: begin
        eng_addr = idx_q + ADDR_W'(COLS);
        if (!cpu_req_i)
          state_d = SCR_CAP;
      end
      // read data lands here; port is free for the CPU
      SCR_CAP: begin
        hold_d  = mem_rdata_i;
        state_d = SCR_WR;
      end
      SCR_WR: begin
        eng_addr  = idx_q;
        eng_we    = 1'b1;
        eng_wdata = hold_q;
        if (!cpu_req_i) begin
          if (idx_q == ADDR_W'(SCROLL_LAST)) begin
            idx_d   = ADDR_W'(SCROLL_LAST + 1);
            end_d   = ADDR_W'(SCREEN_SIZE - 1);
            state_d = FILL;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = SCR_RD;
          end
        end
      end
      FILL: begin
        eng_addr  = idx_q;
        eng_we    = 1'b1;
        eng_wdata = fchar_q;
        if (!cpu_req_i) begin
          if (idx_q == end_q)
            state_d = DONE;
          else
            idx_d = idx_q + ADDR_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // current-cycle port use still completes
    if (abort_i && state_q != IDLE)
      state_d = IDLE;
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);

  assign mem_addr_o  = cpu_req_i ? cpu_addr_i  : eng_addr;
  assign mem_we_o    = cpu_req_i ? cpu_we_i    : eng_we;
  assign mem_wdata_o = cpu_req_i ? cpu_wdata_i : eng_wdata;
  assign cpu_rdata_o = mem_rdata_i;

endmodule

// File: tb/tb_charbuf_scroll_ctrl.sv
// Scoreboard bench for charbuf_scroll_ctrl with a
// behavioural RAM and screen-level reference model.
module tb_charbuf_scroll_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cmd_valid_i;
  logic [1:0]  cmd_i;
  logic [7:0]  fill_char_i;
  logic [4:0]  line_i;
  logic        abort_i;
  logic        cmd_ready_o;
  logic        busy_o;
  logic        done_o;
  logic        cpu_req_i;
  logic        cpu_we_i;
  logic [11:0] cpu_addr_i;
  logic [7:0]  cpu_wdata_i;
  logic [7:0]  cpu_rdata_o;
  logic [11:0] mem_addr_o;
  logic        mem_we_o;
  logic [7:0]  mem_wdata_o;
  logic [7:0]  mem_rdata_i;

  charbuf_scroll_ctrl dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_i       (cmd_i),
    .fill_char_i (fill_char_i),
    .line_i      (line_i),
    .abort_i     (abort_i),
    .cmd_ready_o (cmd_ready_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_wdata_i (cpu_wdata_i),
    .cpu_rdata_o (cpu_rdata_o),
    .mem_addr_o  (mem_addr_o),
    .mem_we_o    (mem_we_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  logic [7:0]  ram [0:4095];
  logic [7:0]  golden [0:2399];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          exp_done [$];
  logic [19:0] exp_wr [$];
  logic [7:0]  exp_rd [$];
  logic        rd_chk;
  logic        rd_pend = 1'b0;
  logic        done_q = 1'b0;
  bit          pat [0:16383];

  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (mem_we_o) ram[mem_addr_o] <= mem_wdata_o;
    mem_rdata_i <= ram[mem_addr_o];
  end

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h",
               nm, act, exp);
    end
  endtask

  task automatic fail_ev(input string nm,
                         input logic [31:0] act);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got %0h required none",
             nm, act);
  endtask

  // monitor: pops expectations when the DUT acts
  always @(negedge clk_i) begin
    if (rst_i) begin
      rd_pend <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      if (rd_pend) begin
        if (exp_rd.size() == 0)
          fail_ev("cpu_rd_unexp", 32'(cpu_rdata_o));
        else
          check("cpu_rdata", 32'(cpu_rdata_o),
                32'(exp_rd.pop_front()));
      end
      rd_pend <= cpu_req_i && !cpu_we_i && rd_chk;
      if (mem_we_o && !cpu_req_i) begin
        if (exp_wr.size() == 0)
          fail_ev("eng_wr_unexp",
                  32'({mem_addr_o, mem_wdata_o}));
        else
          check("eng_wr", 32'({mem_addr_o, mem_wdata_o}),
                32'(exp_wr.pop_front()));
      end
      if (done_o) begin
        if (exp_done.size() == 0)
          fail_ev("done_unexp", 32'(cyc));
        else
          check("done_cyc", 32'(cyc),
                32'(exp_done.pop_front()));
      end
      if (done_q)
        check("idle_after_done",
              32'({busy_o, cmd_ready_o}), 32'h1);
      done_q <= done_o;
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_in();
    cmd_valid_i = 1'b0;
    cmd_i       = 2'b00;
    abort_i     = 1'b0;
    cpu_req_i   = 1'b0;
    cpu_we_i    = 1'b0;
    cpu_addr_i  = '0;
    cpu_wdata_i = '0;
    rd_chk      = 1'b0;
  endtask

  task automatic preload();
    for (int a = 0; a < 2400; a++) begin
      cpu_req_i   = 1'b1;
      cpu_we_i    = 1'b1;
      cpu_addr_i  = 12'(a);
      cpu_wdata_i = 8'(a);
      golden[a]   = 8'(a);
      step();
    end
    idle_in();
    step();
  endtask

  task automatic cpu_reads(input int n);
    int a;
    for (int i = 0; i < n; i++) begin
      a = $urandom_range(2399);
      cpu_req_i  = 1'b1;
      cpu_we_i   = 1'b0;
      cpu_addr_i = 12'(a);
      rd_chk     = 1'b1;
      exp_rd.push_back(golden[a]);
      step();
    end
    idle_in();
    step();
    step();
  endtask

  task automatic check_buffer(input string nm);
    int bad = 0;
    for (int a = 0; a < 2400; a++)
      if (ram[a] !== golden[a]) bad++;
    check(nm, 32'(bad), 32'd0);
  endtask

  // Reference: the screen-level effect of a command
  // plus the list of port slots it needs.
  task automatic run_cmd(input logic [1:0] c,
                         input logic [7:0] fc,
                         input logic [4:0] ln,
                         input int pct,
                         input int abort_at,
                         input int rst_at,
                         input int busy_at,
                         input int capw_at);
    logic [7:0]  pre [0:2399];
    logic [19:0] ew [$];
    bit          dem [$];
    int          lat, t, p, acc, n, base;
    bit          want_done;
    for (int a = 0; a < 2400; a++) pre[a] = golden[a];
    if (capw_at > 0) pre[100] = 8'hA5;
    pat[0] = 1'b0;
    for (int k = 1; k < 16384; k++)
      pat[k] = ($urandom_range(99) < pct);
    if (capw_at > 0) pat[capw_at] = 1'b1;
    want_done = (c != 2'b00);
    if (c == 2'b01) begin
      for (int i = 0; i < 2320; i++) begin
        dem.push_back(1'b1);
        dem.push_back(1'b0);
        dem.push_back(1'b1);
        ew.push_back({12'(i), pre[i + 80]});
      end
      for (int i = 2320; i < 2400; i++) begin
        dem.push_back(1'b1);
        ew.push_back({12'(i), fc});
      end
    end else if (c == 2'b10) begin
      for (int i = 0; i < 2400; i++) begin
        dem.push_back(1'b1);
        ew.push_back({12'(i), fc});
      end
    end else if (c == 2'b11 && ln < 30) begin
      base = int'(ln) * 80;
      for (int i = base; i < base + 80; i++) begin
        dem.push_back(1'b1);
        ew.push_back({12'(i), fc});
      end
    end
    if (abort_at > 0) begin
      want_done = 1'b0;
      while (ew.size() > abort_at) void'(ew.pop_back());
    end
    if (rst_at > 0) want_done = 1'b0;
    t = 0;
    p = 0;
    while (p < dem.size() && t < 16000) begin
      t++;
      if (!(dem[p] && pat[t])) p++;
    end
    lat = t + 1;
    foreach (ew[i]) exp_wr.push_back(ew[i]);
    if (rst_at == 0)
      foreach (ew[i]) golden[ew[i][19:8]] = ew[i][7:0];
    cmd_valid_i = 1'b1;
    cmd_i       = c;
    fill_char_i = fc;
    line_i      = ln;
    acc         = cyc;
    check("ready_at_accept", 32'(cmd_ready_o), 32'd1);
    if (want_done) exp_done.push_back(acc + lat);
    n = want_done ? lat + 3 :
        (abort_at > 0) ? abort_at + 3 :
        (rst_at > 0) ? rst_at : 3;
    for (int k = 1; k <= n; k++) begin
      step();
      idle_in();
      fill_char_i = ~fc;
      line_i      = ln + 5'd1;
      if (pat[k]) begin
        cpu_req_i  = 1'b1;
        cpu_addr_i = 12'($urandom_range(2399));
      end
      if (k == capw_at) begin
        cpu_we_i    = 1'b1;
        cpu_addr_i  = 12'd100;
        cpu_wdata_i = 8'hA5;
      end
      if (capw_at > 0 && k == capw_at + 1)
        check("cpu_wr_immediate", 32'(ram[100]), 32'hA5);
      if (k == busy_at) begin
        cmd_valid_i = 1'b1;
        cmd_i       = 2'b10;
      end
      if (k == abort_at) abort_i = 1'b1;
      if (abort_at > 0 && k == abort_at + 1) begin
        check("abort_ready", 32'(cmd_ready_o), 32'd1);
        check("abort_busy", 32'(busy_o), 32'd0);
      end
      if (k == rst_at) begin
        check("busy_mid", 32'(busy_o), 32'd1);
        #2 rst_i = 1'b1;
        #1;
        check("rst_ready", 32'(cmd_ready_o), 32'd1);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_we", 32'(mem_we_o), 32'd0);
        check("rst_addr", 32'(mem_addr_o), 32'd0);
        exp_wr.delete();
        exp_done.delete();
      end
    end
    idle_in();
    step();
    step();
    step();
    if (rst_at > 0) begin
      rst_i = 1'b0;
      step();
      preload();
    end else begin
      check("done_pending", 32'(exp_done.size()), 32'd0);
      check("wr_pending", 32'(exp_wr.size()), 32'd0);
      check_buffer("buffer");
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1);
  end

  initial begin
    rst_i       = 1'b1;
    fill_char_i = '0;
    line_i      = '0;
    idle_in();
    step();
    step();
    check("reset_ready", 32'(cmd_ready_o), 32'd1);
    check("reset_busy", 32'(busy_o), 32'd0);
    check("reset_done", 32'(done_o), 32'd0);
    check("reset_we", 32'(mem_we_o), 32'd0);
    check("reset_addr", 32'(mem_addr_o), 32'd0);
    rst_i = 1'b0;
    step();

    run_cmd(2'b10, 8'h20, 5'd0, 0, 0, 0, 0, 0);
    cpu_reads(8);

    preload();
    run_cmd(2'b01, 8'h2E, 5'd0, 0, 0, 0, 0, 0);
    check("scroll_a0", 32'(ram[0]), 32'h50);
    check("scroll_a2319", 32'(ram[2319]), 32'h5F);
    check("scroll_a2320", 32'(ram[2320]), 32'h2E);

    run_cmd(2'b11, 8'h41, 5'd5, 0, 0, 0, 0, 0);
    run_cmd(2'b11, 8'h42, 5'd30, 0, 0, 0, 0, 0);
    run_cmd(2'b11, 8'h43, 5'd29, 0, 0, 0, 0, 0);
    run_cmd(2'b11, 8'h44, 5'd0, 0, 0, 0, 0, 0);
    run_cmd(2'b11, 8'h45, 5'd31, 0, 0, 0, 0, 0);
    run_cmd(2'b00, 8'h46, 5'd2, 0, 0, 0, 0, 0);
    check("nop_ready", 32'(cmd_ready_o), 32'd1);

    preload();
    run_cmd(2'b01, 8'h2E, 5'd0, 30, 0, 0, 0, 0);

    preload();
    run_cmd(2'b01, 8'h7E, 5'd0, 0, 0, 0, 50, 2);
    check("capw_a20", 32'(ram[20]), 32'hA5);

    run_cmd(2'b10, 8'h55, 5'd0, 0, 1000, 0, 0, 0);
    cpu_reads(8);

    abort_i = 1'b1;
    step();
    idle_in();
    step();
    check("abort_idle_ready", 32'(cmd_ready_o), 32'd1);

    run_cmd(2'b11, 8'h66, 5'd3, 0, 80, 0, 0, 0);
    run_cmd(2'b11, 8'h67, 5'd7, 0, 0, 0, 20, 0);

    for (int i = 0; i < 4; i++)
      run_cmd(2'b11, 8'($urandom), 5'($urandom_range(31)),
              $urandom_range(40), 0, 0, 0, 0);

    preload();
    run_cmd(2'b01, 8'h2E, 5'd0, 0, 0, 3000, 0, 0);
    run_cmd(2'b11, 8'h30, 5'd12, 25, 0, 0, 0, 0);
    cpu_reads(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/charbuf_scroll_ctrl.md
Name: charbuf_scroll_ctrl

Overview:
- Hardware text-buffer engine that owns the CPU-side port of the 80x30 character buffer dual-port RAM.
- Executes SCROLL_UP, CLEAR and FILL_LINE commands so software does not copy 2400 bytes itself.
- Arbitrates that port between live CPU register accesses, which always have priority, and the engine, which stalls.
- Sits between the video register decode and the charbuf RAM port A.

Parameters:
COLS, 80, characters per line
ROWS, 30, lines per screen
ADDR_W, 12, charbuf address width
DATA_W, 8, character width

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous active-high reset
cmd_valid_i  in  1  command strobe
cmd_i  in  2  01 SCROLL_UP, 10 CLEAR, 11 FILL_LINE, 00 reserved
fill_char_i  in  DATA_W  fill character, sampled at accept
line_i  in  5  target line for FILL_LINE, sampled at accept
abort_i  in  1  synchronous abort of a running command
cmd_ready_o  out  1  high when idle; command accepted on cmd_valid_i && cmd_ready_o
busy_o  out  1  engine running
done_o  out  1  one-cycle pulse when a command completes
cpu_req_i  in  1  CPU accesses port this cycle
cpu_we_i  in  1  CPU write
cpu_addr_i  in  ADDR_W  CPU address (already Y*80+X)
cpu_wdata_i  in  DATA_W  CPU write data
cpu_rdata_o  out  DATA_W  read data, equal to mem_rdata_i
mem_addr_o  out  ADDR_W  RAM port address
mem_we_o  out  1  RAM port write enable
mem_wdata_o  out  DATA_W  RAM port write data
mem_rdata_i  in  DATA_W  RAM read data, 1-cycle latency

Behaviour:
- Reset: state IDLE, busy_o=0, done_o=0, cmd_ready_o=1, idx=0, hold=0, mem_we_o=0, mem_addr_o=0.
- Port mux is combinational.
  - cpu_req_i=1: mem_* driven by the CPU, whatever the engine state.
  - Otherwise: mem_* driven by the engine's current port use, or addr=0 and we=0 when the engine needs no port.
- Accept: in IDLE with cmd_valid_i=1, latch cmd, fill_char_i and line_i; busy_o=1 from the next cycle.
  - cmd 00: accepted with no effect and no done_o.
  - FILL_LINE with line_i >= ROWS: no writes; done_o pulses 1 cycle after accept.
- States: IDLE, SCR_RD, SCR_CAP, SCR_WR, FILL, DONE.
- SCROLL_UP: idx runs 0..COLS*(ROWS-1)-1 (0..2319).
  - SCR_RD: read address idx+COLS. Needs the port: if cpu_req_i=1, stay; else go to SCR_CAP.
  - SCR_CAP: hold <= mem_rdata_i. Does not use the port, so the CPU is never blocked here. Always advances to SCR_WR.
  - SCR_WR: write hold to address idx. Needs the port; stall while cpu_req_i=1.
  - After SCR_WR, if idx is the last index, set idx=COLS*(ROWS-1) and go to FILL with end=COLS*ROWS-1. Otherwise idx+1 and go to SCR_RD.
- CLEAR: FILL with idx=0, end=2399.
- FILL_LINE: FILL with idx=line*80 (width-exact 12-bit arithmetic) and end=idx+79.
- FILL: write fill_char to idx, one write per non-stalled cycle. At idx==end go to DONE.
- DONE: done_o=1 for 1 cycle, then IDLE; cmd_ready_o=1 in that following cycle.
- Stall rule: no port cycle is lost or duplicated. idx and state advance only when the engine actually owned the port.
- Uncontended timing:
  - SCROLL_UP: 3*2320 + 80 + 1 = 7041 cycles from accept to done_o.
  - CLEAR: 2401 cycles.
  - FILL_LINE: 81 cycles.
- abort_i while busy: IDLE next cycle, no done_o, no further engine writes; partial buffer content stays.
- abort_i in IDLE: ignored.
- Simultaneous abort_i and a final write: the write completes and done_o is suppressed.
- cmd_valid_i while busy: ignored (not queued).
- rst_i mid-operation: immediate IDLE; RAM content undefined-partial.

Decomposition:
- Package charbuf_pkg holds:
  - cmd encodings CMD_NOP, CMD_SCROLL, CMD_CLEAR, CMD_FILL_LINE;
  - the state enum;
  - COLS, ROWS, SCREEN_SIZE=2400, SCROLL_LAST=2319.
- Single module; no sub-module. A line*80 helper function (shift-add, 16*l + 64*l) goes in the package.

Test Plan:
- CLEAR, fill 0x20, no CPU traffic -> 2400 writes of 0x20 to addresses 0..2399, done_o at cycle 2401 after accept, busy_o low next cycle.
- Buffer preloaded addr=value&0xFF, SCROLL_UP fill 0x2E -> addr 0 holds old addr 80; addr 2319 holds old 2399; 2320..2399 = 0x2E; done_o at cycle 7041.
- FILL_LINE line 5, 0x41 during CLEAR-free idle -> writes only 400..479; line_i=30 -> zero writes, done_o 1 cycle after accept.
- SCROLL_UP with random cpu_req_i reads (~30%) -> CPU always gets the port; final buffer is identical to the no-contention result; completion delayed by exactly the CPU cycles that landed on SCR_RD/SCR_WR/FILL.
- CPU write to addr 100 during SCR_CAP -> written immediately, engine unaffected; cmd_valid_i while busy -> ignored, no second done_o.
- abort_i at cycle 1000 of CLEAR -> no writes after next cycle, no done_o, cmd_ready_o=1; rst_i asserted mid-scroll -> all outputs at reset values asynchronously.
